// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// CNT_W_DEFAULT / DIV_DEFAULT seed the top-level parameters; div_t is the
// default-width divide value used by software-facing code and benches.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam int unsigned DIV_DEFAULT   = 500000000;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, active/pending divide value,
// registered clk_out and tick. A new divide value waits in the pending
// slot and only takes effect on a half-period boundary or while idle.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned      CNT_W       = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DIV_DEFAULT)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             busy,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_pend;

  // Counter, output phase and reload; an idle or restarting channel adopts a
  // pending value at once, a running one only when its half-period ends.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt      <= '0;
      div_act  <= DEFAULT_DIV;
      div_pend <= '0;
      busy     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (!en || sync || (div_act == '0)) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (busy) begin
          div_act <= div_pend;
          busy    <= 1'b0;
        end
      end else if (cnt == div_act - CNT_W'(1)) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
        if (busy) begin
          div_act <= div_pend;
          busy    <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      // A load is only granted while nothing is pending, so it never
      // collides with the reload above; the boundary uses the old value.
      if (load) begin
        div_pend <= load_div;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_clk_divider.sv
// Multi-channel runtime-programmable clock divider and tick generator.
// Config port accepts one new half-period per channel at a time; cfg_ready is
// the only combinational output. Optional macro CLKDIV_SYNC_EN adds sync_pulse,
// which restarts all enabled channels phase-aligned.
module multi_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      CNT_W       = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DIV_DEFAULT),
  localparam int unsigned     CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_pulse,
`endif
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic              sync;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] load;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_pulse;
`else
  assign sync = 1'b0;
`endif

  // Ready follows the pending flag of the addressed channel; an index past
  // the last channel is always ready and the write simply lands nowhere.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~busy[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .reset    (reset),
      .en       (ch_en[g]),
      .sync     (sync),
      .load     (load[g]),
      .load_div (cfg_div),
      .busy     (busy[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Bench for multi_clk_divider: expected clk_out/tick per cycle come from a
// closed-form phase formula per channel segment (start, half-period, level),
// queued before each edge and compared after it.
module tb_multi_clk_divider;
  import clkdiv_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 32;
  localparam int CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  div_t              cfg_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic              sync_pulse = 1'b0;
`endif

  typedef struct packed {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tck;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  bit   ref_on   [NUM_CH];
  int   ref_start[NUM_CH];
  int   ref_d    [NUM_CH];
  bit   ref_lvl  [NUM_CH];

  multi_clk_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (32'd3)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .ch_en      (ch_en),
    .cfg_valid  (cfg_valid),
`ifdef CLKDIV_SYNC_EN
    .sync_pulse (sync_pulse),
`endif
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Channel ch runs with half-period d from the current edge, level lvl now.
  task automatic set_seg(input int ch, input int d, input bit lvl);
    ref_on[ch]    = 1'b1;
    ref_start[ch] = cyc;
    ref_d[ch]     = d;
    ref_lvl[ch]   = lvl;
  endtask

  task automatic seg_off(input int ch);
    ref_on[ch] = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    exp_t o;
    int   t;
    cyc++;
    e = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (ref_on[ch]) begin
        t          = cyc - ref_start[ch];
        e.clk[ch]  = ref_lvl[ch] ^ (((t / ref_d[ch]) % 2) == 1);
        e.tck[ch]  = (t > 0) && ((t % ref_d[ch]) == 0) && e.clk[ch];
      end
    end
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    o = sb_q.pop_front();
    check("clk_out", 32'(clk_out), 32'(o.clk));
    check("tick", 32'(tick), 32'(o.tck));
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    #1;
    check(tag, 32'(cfg_ready), 32'(exp));
  endtask

  initial begin
    reset     = 1'b1;
    ch_en     = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) seg_off(ch);

    // Reset state
    repeat (2) step();
    reset = 1'b0;
    chk_rdy("rdy_after_reset", 1'b1);
    repeat (2) step();

    // T1: default half-period 3
    ch_en = 3'b001;
    set_seg(0, 3, 1'b0);
    repeat (12) step();

    // T2: reload 5 written at cnt=1, takes effect at the next boundary
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 5;
    chk_rdy("t2_rdy_pre", 1'b1);
    step();
    cfg_valid = 1'b0;
    chk_rdy("t2_rdy_pending", 1'b0);
    step();
    set_seg(0, 5, 1'b1);
    chk_rdy("t2_rdy_applied", 1'b1);
    repeat (20) step();

    // T3: busy channel refuses, another channel accepts in the same cycle
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 4;
    step();
    cfg_div = 7;
    chk_rdy("t3_ch0_busy", 1'b0);
    cfg_ch = 2'd1; cfg_div = 2;
    chk_rdy("t3_ch1_free", 1'b1);
    step();
    cfg_valid = 1'b0;
    chk_rdy("t3_ch1_pend", 1'b0);
    step();
    chk_rdy("t3_ch1_applied", 1'b1);
    cfg_ch = 2'd0;
    chk_rdy("t3_ch0_still", 1'b0);
    step();
    set_seg(0, 4, 1'b0);
    chk_rdy("t3_ch0_done", 1'b1);
    repeat (8) step();
    ch_en = 3'b011;
    set_seg(1, 2, 1'b0);
    repeat (8) step();

    // T4: div=0 stops at the next boundary, then div=2 restarts
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 0;
    step();
    cfg_valid = 1'b0;
    repeat (3) step();
    seg_off(0);
    repeat (6) step();
    chk_rdy("t4_rdy_idle", 1'b1);
    cfg_valid = 1'b1; cfg_div = 2;
    step();
    cfg_valid = 1'b0;
    step();
    set_seg(0, 2, 1'b0);
    repeat (6) step();

    // T5: drop enable while high, then re-raise
    ch_en = 3'b010;
    seg_off(0);
    repeat (4) step();
    ch_en = 3'b011;
    set_seg(0, 2, 1'b0);
    repeat (7) step();

    // T6: reset mid-period, then out-of-range channel write is discarded
    reset = 1'b1;
    seg_off(0); seg_off(1);
    repeat (2) step();
    reset = 1'b0;
    set_seg(0, 3, 1'b0);
    set_seg(1, 3, 1'b0);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 1;
    chk_rdy("oob_ready", 1'b1);
    step();
    cfg_valid = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cfg_ch = CH_W'(ch);
      chk_rdy("oob_no_pending", 1'b1);
    end
    repeat (8) step();

`ifdef CLKDIV_SYNC_EN
    // Sync: channels with half-periods 2 and 3 restart aligned
    ch_en = 3'b000;
    seg_off(0); seg_off(1);
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 2;
    step();
    cfg_valid = 1'b0;
    step();
    ch_en = 3'b011;
    set_seg(0, 2, 1'b0);
    set_seg(1, 3, 1'b0);
    repeat (5) step();
    sync_pulse = 1'b1;
    seg_off(0); seg_off(1);
    step();
    sync_pulse = 1'b0;
    set_seg(0, 2, 1'b0);
    set_seg(1, 3, 1'b0);
    repeat (7) step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
